// File: rtl/fma_mul_res_receiver.sv
// fma_mul_res_receiver
// Adder-side receiver for the multiplier's FMA intermediate product bundle.
// Each accepted bundle is split into sign/exponent/fraction for its format
// and decoded into one format-independent product operand, which is then
// registered for the adder datapath.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   fma_mul_valid_i/ready_o    upstream handshake
//   format_i                   one-hot {f64,f32,f16}, captured with the bundle
//   fma_intermediate_res_i     packed product (f16 [26:0], f32 [55:0], f64 [116:0])
//   fma_mul_sticky_i           bits lost by the multiplier's right shift
//   fma_inputs_nan_inf_i       a multiplier input had an all-ones exponent
//   fma_mul_exp_gt_inf_i       product exponent beyond the infinity exponent
//   prod_valid_o/ready_i       downstream handshake
//   prod_*                     registered unpacked product operand
//
// Build option:
//   FMA_MUL_RECV_SKID_EN  defined   -> OUT register plus one skid entry,
//                                      registered upstream ready.
//                         undefined -> single OUT register, upstream ready
//                                      passes prod_ready_i through.

module fma_mul_res_receiver #(
    parameter int SIG_W = 106,
    parameter int EXP_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fma_mul_valid_i,
    output logic             fma_mul_ready_o,
    input  logic [2:0]       format_i,
    input  logic [116:0]     fma_intermediate_res_i,
    input  logic             fma_mul_sticky_i,
    input  logic             fma_inputs_nan_inf_i,
    input  logic             fma_mul_exp_gt_inf_i,
    output logic             prod_valid_o,
    input  logic             prod_ready_i,
    output logic [2:0]       prod_format_o,
    output logic             prod_sign_o,
    output logic [EXP_W-1:0] prod_exp_o,
    output logic [SIG_W-1:0] prod_sig_o,
    output logic             prod_sticky_o,
    output logic             prod_is_zero_o,
    output logic             prod_is_inf_o,
    output logic             prod_is_nan_o,
    output logic             prod_invalid_o,
    output logic             prod_overflow_o
);

    localparam int FRAC_W = SIG_W - 1;

    typedef struct packed {
        logic [2:0]       format;
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [SIG_W-1:0] sig;
        logic             sticky;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
        logic             invalid;
        logic             overflow;
    } prod_t;

    localparam int    PROD_W   = $bits(prod_t);
    // Format sits in the top bits; reset leaves it at f64 with all data zero.
    localparam prod_t PROD_RST = prod_t'({3'b100, {(PROD_W - 3){1'b0}}});

    prod_t            dec;
    prod_t            out_q;
    logic             accept;
    logic             drain;
    logic             f_sign;
    logic [EXP_W-1:0] f_exp;
    logic [EXP_W-1:0] f_emax;
    logic [FRAC_W-1:0] f_frac;
    logic             f_msb;

    // Split the bundle by format. Fractions are left-justified into the
    // common 105-bit field so the adder never needs to know the format.
    always_comb begin
        f_sign = 1'b0;
        f_exp  = '0;
        f_emax = '0;
        f_frac = '0;
        f_msb  = 1'b0;
        if (format_i[2]) begin
            f_sign = fma_intermediate_res_i[116];
            f_exp  = fma_intermediate_res_i[115:105];
            f_emax = 11'h7FF;
            f_frac = fma_intermediate_res_i[104:0];
            f_msb  = fma_intermediate_res_i[104];
        end else if (format_i[1]) begin
            f_sign = fma_intermediate_res_i[55];
            f_exp  = {{(EXP_W - 8){1'b0}}, fma_intermediate_res_i[54:47]};
            f_emax = {{(EXP_W - 8){1'b0}}, 8'hFF};
            f_frac = {fma_intermediate_res_i[46:0], 58'b0};
            f_msb  = fma_intermediate_res_i[46];
        end else begin
            f_sign = fma_intermediate_res_i[26];
            f_exp  = {{(EXP_W - 5){1'b0}}, fma_intermediate_res_i[25:21]};
            f_emax = {{(EXP_W - 5){1'b0}}, 5'h1F};
            f_frac = {fma_intermediate_res_i[20:0], 84'b0};
            f_msb  = fma_intermediate_res_i[20];
        end
    end

    // Classify the product. Denormals and zeros report exponent 1 so the
    // adder can align them like normals with a clear hidden bit. A NaN with
    // a clear fraction MSB is the multiplier's sNaN marker and raises NV.
    // Overflow is suppressed when a special input already decides the result.
    always_comb begin
        dec          = PROD_RST;
        dec.format   = format_i;
        dec.sign     = f_sign;
        dec.exponent = (f_exp == '0) ? {{(EXP_W - 1){1'b0}}, 1'b1} : f_exp;
        dec.sig      = {(f_exp != '0), f_frac};
        dec.sticky   = fma_mul_sticky_i;
        dec.is_zero  = (f_exp == '0) && (f_frac == '0);
        dec.is_inf   = (f_exp == f_emax) && (f_frac == '0);
        dec.is_nan   = (f_exp == f_emax) && (f_frac != '0);
        dec.invalid  = (f_exp == f_emax) && (f_frac != '0) && !f_msb;
        dec.overflow = fma_mul_exp_gt_inf_i && !fma_inputs_nan_inf_i;
    end

    assign drain = prod_valid_o & prod_ready_i;

`ifdef FMA_MUL_RECV_SKID_EN

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    prod_t      skid_q;
    logic       ready_q;

    assign fma_mul_ready_o = ready_q;
    assign accept          = fma_mul_valid_i & ready_q;
    assign prod_valid_o    = (state_q != ST_EMPTY);

    // Occupancy of OUT plus SKID; FULL is the only state that refuses input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !drain)      state_d = ST_FULL;
                else if (!accept && drain) state_d = ST_EMPTY;
            end
            ST_FULL:  if (drain) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Ready is computed from the next state so it is a pure flop output and
    // never sees prod_ready_i combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            out_q   <= PROD_RST;
            skid_q  <= PROD_RST;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            case (state_q)
                ST_EMPTY: if (accept) out_q <= dec;
                ST_ONE: begin
                    if (accept && drain) out_q  <= dec;
                    else if (accept)     skid_q <= dec;
                end
                ST_FULL:  if (drain) out_q <= skid_q;
                default:  ;
            endcase
        end
    end

`else

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_ONE   = 1'b1;

    logic [0:0] state_q;

    assign fma_mul_ready_o = (state_q == ST_EMPTY) | prod_ready_i;
    assign accept          = fma_mul_valid_i & fma_mul_ready_o;
    assign prod_valid_o    = (state_q == ST_ONE);

    // Single output register: a new bundle may replace the one leaving in
    // the same cycle, so throughput stays at one per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= PROD_RST;
        end else if (accept) begin
            state_q <= ST_ONE;
            out_q   <= dec;
        end else if (drain) begin
            state_q <= ST_EMPTY;
        end
    end

`endif

    assign prod_format_o   = out_q.format;
    assign prod_sign_o     = out_q.sign;
    assign prod_exp_o      = out_q.exponent;
    assign prod_sig_o      = out_q.sig;
    assign prod_sticky_o   = out_q.sticky;
    assign prod_is_zero_o  = out_q.is_zero;
    assign prod_is_inf_o   = out_q.is_inf;
    assign prod_is_nan_o   = out_q.is_nan;
    assign prod_invalid_o  = out_q.invalid;
    assign prod_overflow_o = out_q.overflow;

endmodule

// File: tb/tb_fma_mul_res_receiver.sv
// tb_fma_mul_res_receiver
// Self-checking bench for fma_mul_res_receiver: a table of hand-derived
// vectors, backpressure and reset sequences, and a randomized run checked
// against a field-arithmetic reference model with an in-order queue.
// Follows FMA_MUL_RECV_SKID_EN the same way the design does.

`timescale 1ns/1ps

module tb_fma_mul_res_receiver;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           fma_mul_valid_i;
    logic           fma_mul_ready_o;
    logic [2:0]     format_i;
    logic [116:0]   fma_intermediate_res_i;
    logic           fma_mul_sticky_i;
    logic           fma_inputs_nan_inf_i;
    logic           fma_mul_exp_gt_inf_i;
    logic           prod_valid_o;
    logic           prod_ready_i;
    logic [2:0]     prod_format_o;
    logic           prod_sign_o;
    logic [10:0]    prod_exp_o;
    logic [105:0]   prod_sig_o;
    logic           prod_sticky_o;
    logic           prod_is_zero_o;
    logic           prod_is_inf_o;
    logic           prod_is_nan_o;
    logic           prod_invalid_o;
    logic           prod_overflow_o;

    fma_mul_res_receiver #(.SIG_W(106), .EXP_W(11)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .fma_mul_valid_i        (fma_mul_valid_i),
        .fma_mul_ready_o        (fma_mul_ready_o),
        .format_i               (format_i),
        .fma_intermediate_res_i (fma_intermediate_res_i),
        .fma_mul_sticky_i       (fma_mul_sticky_i),
        .fma_inputs_nan_inf_i   (fma_inputs_nan_inf_i),
        .fma_mul_exp_gt_inf_i   (fma_mul_exp_gt_inf_i),
        .prod_valid_o           (prod_valid_o),
        .prod_ready_i           (prod_ready_i),
        .prod_format_o          (prod_format_o),
        .prod_sign_o            (prod_sign_o),
        .prod_exp_o             (prod_exp_o),
        .prod_sig_o             (prod_sig_o),
        .prod_sticky_o          (prod_sticky_o),
        .prod_is_zero_o         (prod_is_zero_o),
        .prod_is_inf_o          (prod_is_inf_o),
        .prod_is_nan_o          (prod_is_nan_o),
        .prod_invalid_o         (prod_invalid_o),
        .prod_overflow_o        (prod_overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   fmt;
        logic         sign;
        logic [10:0]  exponent;
        logic [105:0] sig;
        logic         sticky;
        logic         zero;
        logic         inf;
        logic         nan;
        logic         invalid;
        logic         ovf;
    } prod_exp_t;

    typedef struct {
        logic [2:0]   fmt;
        logic [116:0] res;
        logic         sticky;
        logic         ni;
        logic         gt;
        prod_exp_t    want;
    } vec_t;

    int        checks = 0;
    int        errors = 0;
    prod_exp_t exp_q[$];
    vec_t      vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic int exp_width(input logic [2:0] fmt);
        case (fmt)
            3'b001:  return 5;
            3'b010:  return 8;
            default: return 11;
        endcase
    endfunction

    function automatic int frac_width(input logic [2:0] fmt);
        case (fmt)
            3'b001:  return 21;
            3'b010:  return 47;
            default: return 105;
        endcase
    endfunction

    // Reference model: fields pulled out with masks and shifts from the
    // format's widths, then classified from the IEEE-style rules.
    function automatic prod_exp_t model(input logic [2:0] fmt, input logic [116:0] res,
                                        input logic sticky, input logic ni, input logic gt);
        prod_exp_t    p;
        int           ew;
        int           fw;
        logic [116:0] mask_e;
        logic [116:0] mask_f;
        logic [116:0] e_val;
        logic [116:0] f_val;
        logic [104:0] frac;
        ew     = exp_width(fmt);
        fw     = frac_width(fmt);
        mask_e = (117'd1 << ew) - 117'd1;
        mask_f = (117'd1 << fw) - 117'd1;
        e_val  = (res >> fw) & mask_e;
        f_val  = res & mask_f;
        frac   = f_val[104:0] << (105 - fw);
        p.fmt      = fmt;
        p.sign     = res[ew + fw];
        p.exponent = (e_val == 0) ? 11'd1 : e_val[10:0];
        p.sig      = {(e_val != 0), frac};
        p.sticky   = sticky;
        p.zero     = (e_val == 0) && (f_val == 0);
        p.inf      = (e_val == mask_e) && (f_val == 0);
        p.nan      = (e_val == mask_e) && (f_val != 0);
        p.invalid  = p.nan && !f_val[fw - 1];
        p.ovf      = gt && !ni;
        return p;
    endfunction

    function automatic logic [116:0] rand_res(input logic [2:0] fmt);
        logic [127:0] raw;
        logic [116:0] r;
        logic [116:0] me;
        logic [116:0] mf;
        logic [116:0] mt;
        int           ew;
        int           fw;
        ew  = exp_width(fmt);
        fw  = frac_width(fmt);
        raw = {$urandom, $urandom, $urandom, $urandom};
        r   = raw[116:0];
        me  = ((117'd1 << ew) - 117'd1) << fw;
        mf  = (117'd1 << fw) - 117'd1;
        mt  = (117'd1 << (ew + fw + 1)) - 117'd1;
        case ($urandom_range(0, 7))
            0:       r = r & ~me;
            1:       r = r | me;
            2:       r = (r | me) & ~mf;
            3:       r = r & ~me & ~mf;
            4:       r = (r | me) & ~(117'd1 << (fw - 1));
            default: ;
        endcase
        return r & mt;
    endfunction

    function automatic logic [2:0] rand_fmt();
        case ($urandom_range(0, 2))
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic prod_exp_t mk(input logic [2:0] fmt, input logic sign, input logic [10:0] e,
                                     input logic [105:0] sig, input logic sticky, input logic zero,
                                     input logic inf, input logic nan, input logic inv, input logic ovf);
        prod_exp_t p;
        p.fmt = fmt; p.sign = sign; p.exponent = e; p.sig = sig; p.sticky = sticky;
        p.zero = zero; p.inf = inf; p.nan = nan; p.invalid = inv; p.ovf = ovf;
        return p;
    endfunction

    task automatic apply_stimulus(input logic valid, input logic [2:0] fmt, input logic [116:0] res,
                                  input logic sticky, input logic ni, input logic gt);
        fma_mul_valid_i        = valid;
        format_i               = fmt;
        fma_intermediate_res_i = res;
        fma_mul_sticky_i       = sticky;
        fma_inputs_nan_inf_i   = ni;
        fma_mul_exp_gt_inf_i   = gt;
    endtask

    task automatic check_output(input string tag, input prod_exp_t e);
        chk({tag, ".format"},   prod_format_o,   e.fmt);
        chk({tag, ".sign"},     prod_sign_o,     e.sign);
        chk({tag, ".exp"},      prod_exp_o,      e.exponent);
        chk({tag, ".sig"},      prod_sig_o,      e.sig);
        chk({tag, ".sticky"},   prod_sticky_o,   e.sticky);
        chk({tag, ".is_zero"},  prod_is_zero_o,  e.zero);
        chk({tag, ".is_inf"},   prod_is_inf_o,   e.inf);
        chk({tag, ".is_nan"},   prod_is_nan_o,   e.nan);
        chk({tag, ".invalid"},  prod_invalid_o,  e.invalid);
        chk({tag, ".overflow"}, prod_overflow_o, e.ovf);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".prod_valid"}, prod_valid_o, 1'b0);
        chk({tag, ".mul_ready"},  fma_mul_ready_o, 1'b1);
        check_output(tag, mk(3'b100, 1'b0, 11'd0, 106'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // One clock of the queue-based checker. Entered at posedge+1 with the
    // inputs already driven; samples at the falling edge and returns at the
    // next posedge+1.
    task automatic run_cycle(output logic accepted, output logic ready_seen);
        logic popped;
        #4;
        chk("prod_valid", prod_valid_o, (exp_q.size() > 0));
`ifdef FMA_MUL_RECV_SKID_EN
        chk("mul_ready", fma_mul_ready_o, (exp_q.size() < 2));
`else
        chk("mul_ready", fma_mul_ready_o, (exp_q.size() == 0) || prod_ready_i);
`endif
        if (prod_valid_o && exp_q.size() > 0) check_output("stream", exp_q[0]);
        accepted   = fma_mul_valid_i && fma_mul_ready_o;
        ready_seen = fma_mul_ready_o;
        popped     = prod_valid_o && prod_ready_i;
        if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
        if (accepted)
            exp_q.push_back(model(format_i, fma_intermediate_res_i, fma_mul_sticky_i,
                                  fma_inputs_nan_inf_i, fma_mul_exp_gt_inf_i));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic         acc;
        logic         rdy;
        logic         hold;
        int           sent;
        int           drop_at;
        logic [2:0]   bp_fmt[4];
        logic [116:0] bp_res[4];

        vecs[0] = '{3'b001, 117'h1F00000, 1'b0, 1'b0, 1'b0,
                    mk(3'b001, 0, 11'd15, 106'h3 << 104, 0, 0, 0, 0, 0, 0)};
        vecs[1] = '{3'b010, (117'hFF << 47) | (117'h1 << 24), 1'b0, 1'b1, 1'b0,
                    mk(3'b010, 0, 11'd255, (106'h1 << 105) | (106'h1 << 82), 0, 0, 0, 1, 1, 0)};
        vecs[2] = '{3'b100, 117'h1 << 100, 1'b1, 1'b0, 1'b0,
                    mk(3'b100, 0, 11'd1, 106'h1 << 100, 1, 0, 0, 0, 0, 0)};
        vecs[3] = '{3'b001, 117'h1F00000, 1'b0, 1'b0, 1'b1,
                    mk(3'b001, 0, 11'd15, 106'h3 << 104, 0, 0, 0, 0, 0, 1)};
        vecs[4] = '{3'b001, 117'h1F00000, 1'b0, 1'b1, 1'b1,
                    mk(3'b001, 0, 11'd15, 106'h3 << 104, 0, 0, 0, 0, 0, 0)};
        vecs[5] = '{3'b100, (117'h1 << 116) | (117'h7FF << 105), 1'b0, 1'b1, 1'b0,
                    mk(3'b100, 1, 11'h7FF, 106'h1 << 105, 0, 0, 1, 0, 0, 0)};
        vecs[6] = '{3'b010, 117'h1 << 55, 1'b0, 1'b0, 1'b0,
                    mk(3'b010, 1, 11'd1, 106'h0, 0, 1, 0, 0, 0, 0)};
        vecs[7] = '{3'b010, (117'hFF << 47) | (117'h1 << 46), 1'b0, 1'b1, 1'b0,
                    mk(3'b010, 0, 11'd255, (106'h1 << 105) | (106'h1 << 104), 0, 0, 0, 1, 0, 0)};
        vecs[8] = '{3'b001, (117'h1F << 21) | 117'h1, 1'b0, 1'b1, 1'b0,
                    mk(3'b001, 0, 11'd31, (106'h1 << 105) | (106'h1 << 84), 0, 0, 0, 1, 1, 0)};
        vecs[9] = '{3'b100, (117'h3FF << 105) | (117'h1 << 104) | 117'h1, 1'b0, 1'b0, 1'b0,
                    mk(3'b100, 0, 11'h3FF, (106'h1 << 105) | (106'h1 << 104) | 106'h1, 0, 0, 0, 0, 0, 0)};

        rst_n        = 1'b0;
        prod_ready_i = 1'b0;
        apply_stimulus(1'b0, 3'b100, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) begin
            prod_ready_i = 1'b1;
            apply_stimulus(1'b1, vecs[i].fmt, vecs[i].res, vecs[i].sticky, vecs[i].ni, vecs[i].gt);
            run_cycle(acc, rdy);
            chk($sformatf("vec%0d.accept", i), acc, 1'b1);
            fma_mul_valid_i = 1'b0;
            chk($sformatf("vec%0d.valid", i), prod_valid_o, 1'b1);
            check_output($sformatf("vec%0d", i), vecs[i].want);
            run_cycle(acc, rdy);
        end

        $display("[TB] backpressure burst");
        for (int i = 0; i < 4; i++) begin
            bp_fmt[i] = rand_fmt();
            bp_res[i] = rand_res(bp_fmt[i]);
        end
        sent    = 0;
        drop_at = -1;
        for (int cyc = 0; cyc < 30 && (sent < 4 || exp_q.size() > 0); cyc++) begin
            if (sent < 4) apply_stimulus(1'b1, bp_fmt[sent], bp_res[sent], 1'b0, 1'b0, 1'b0);
            else          fma_mul_valid_i = 1'b0;
            prod_ready_i = (cyc >= 3);
            run_cycle(acc, rdy);
            if (!rdy && drop_at < 0) drop_at = sent;
            if (acc) sent++;
        end
`ifdef FMA_MUL_RECV_SKID_EN
        chk("bp.accepts_before_drop", drop_at, 2);
`else
        chk("bp.accepts_before_drop", drop_at, 1);
`endif
        chk("bp.all_sent", sent, 4);
        chk("bp.drained", exp_q.size(), 0);

        $display("[TB] reset mid-burst");
        prod_ready_i = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            apply_stimulus(1'b1, 3'b010, rand_res(3'b010), 1'b1, 1'b0, 1'b1);
            run_cycle(acc, rdy);
            if (acc) fma_mul_valid_i = 1'b0;
        end
        fma_mul_valid_i = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        fma_mul_valid_i = 1'b0;
        check_reset_state("mid_reset");
        exp_q.delete();
        rst_n        = 1'b1;
        prod_ready_i = 1'b1;
        repeat (2) run_cycle(acc, rdy);

        $display("[TB] randomized traffic");
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                format_i = rand_fmt();
                apply_stimulus(($urandom_range(0, 9) < 7), format_i, rand_res(format_i),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
            end
            prod_ready_i = ($urandom_range(0, 9) < 6);
            run_cycle(acc, rdy);
            hold = fma_mul_valid_i && !acc;
        end
        fma_mul_valid_i = 1'b0;
        prod_ready_i    = 1'b1;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) run_cycle(acc, rdy);
        chk("final.drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
